// File: rtl/gpu_pkg.sv
// Shared GPU constants and types: screen geometry, framebuffer pixel record,
// and the framebuffer write-FSM state encoding.
package gpu_pkg;

  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;
  localparam int FB_ADDR_BITS = 19;
  localparam int RGB_BITS     = 3 * CHANNEL_BITS;

  typedef struct packed {
    logic [FB_ADDR_BITS-1:0] addr;
    logic [RGB_BITS-1:0]     rgb;
  } fb_pixel_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fb_wr_state_t;

  // Row-major linear address; 2^FB_ADDR_BITS >= WIDTH*HEIGHT so it never wraps.
  function automatic logic [FB_ADDR_BITS-1:0] xy_to_addr(
    input logic [WIDTH_BITS-1:0]  x,
    input logic [HEIGHT_BITS-1:0] y
  );
    return FB_ADDR_BITS'(y) * FB_ADDR_BITS'(WIDTH) + FB_ADDR_BITS'(x);
  endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// Synchronous FIFO of fb_pixel_t with combinational read data, full/empty flags
// and synchronous active-low reset. A push while full succeeds only with a pop.
module fb_pixel_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      n_rst,
  input  logic      push_i,
  input  fb_pixel_t pix_i,
  input  logic      pop_i,
  output fb_pixel_t pix_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  fb_pixel_t      mem_q [DEPTH];
  logic           push_ok;
  logic           pop_ok;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign pix_o   = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= pix_i;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Rasteriser-to-framebuffer pixel writer: bounds filter, address stage, FIFO and
// req/ack write FSM. Optional FB_PIXEL_DEDUP_EN suppresses repeated (X,Y) pixels.
module fb_pixel_writer
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    pix_en,
  input  logic [WIDTH_BITS-1:0]   X_i,
  input  logic [HEIGHT_BITS-1:0]  Y_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic                    fb_ack,
  input  logic                    clr_ovf,
  output logic                    fb_wr,
  output logic [FB_ADDR_BITS-1:0] fb_addr,
  output logic [RGB_BITS-1:0]     fb_data,
  output logic                    overflow,
  output logic                    idle,
  output fb_wr_state_t            wr_state_o
);

  logic         in_bounds;
  logic         dup;
  logic         accept;
  logic         stage_vld_q;
  fb_pixel_t    stage_pix_q;
  fb_pixel_t    fifo_rd_pix;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         overflow_q, overflow_d;
  fb_wr_state_t state_q, state_d;
  logic [FB_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RGB_BITS-1:0]     data_q, data_d;

  assign in_bounds = (X_i < WIDTH_BITS'(WIDTH)) && (Y_i < HEIGHT_BITS'(HEIGHT));
  assign accept    = pix_en && in_bounds && !dup;

`ifdef FB_PIXEL_DEDUP_EN
  logic                   last_vld_q;
  logic [WIDTH_BITS-1:0]  last_x_q;
  logic [HEIGHT_BITS-1:0] last_y_q;

  assign dup = last_vld_q && (X_i == last_x_q) && (Y_i == last_y_q);

  // Dropping pix_en ends the primitive, so the next one always writes its first pixel.
  always_ff @(posedge clk) begin
    if (!n_rst || !pix_en) begin
      last_vld_q <= 1'b0;
      last_x_q   <= '0;
      last_y_q   <= '0;
    end else if (accept) begin
      last_vld_q <= 1'b1;
      last_x_q   <= X_i;
      last_y_q   <= Y_i;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      stage_vld_q <= 1'b0;
      stage_pix_q <= '0;
    end else begin
      stage_vld_q <= accept;
      stage_pix_q <= '{addr: xy_to_addr(X_i, Y_i), rgb: {r_i, g_i, b_i}};
    end
  end

  fb_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (stage_vld_q),
    .pix_i   (stage_pix_q),
    .pop_i   (fifo_pop),
    .pix_o   (fifo_rd_pix),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The stage never stalls: a push into a full FIFO without a pop is lost.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (stage_vld_q && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  // Handshake: a write transfers on a clk edge where fb_wr=1 and fb_ack=1;
  // while fb_wr=1 and fb_ack=0, fb_addr and fb_data are held stable.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = fifo_rd_pix.addr;
          data_d   = fifo_rd_pix.rgb;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (fb_ack) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            addr_d   = fifo_rd_pix.addr;
            data_d   = fifo_rd_pix.rgb;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign fb_wr      = (state_q == REQ);
  assign fb_addr    = addr_q;
  assign fb_data    = data_q;
  assign overflow   = overflow_q;
  assign wr_state_o = state_q;
  assign idle       = (state_q == IDLE) && fifo_empty && !stage_vld_q && !accept;

endmodule
